calc_arbiter: RTL and testbench



---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_rr_arb.sv | 55 +++++
 rtl/calc_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_calc_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calc arbiter: calc opcodes, datapath width and FSM states.
package calc_pkg;

   localparam int unsigned CALC_DW = 8;
   localparam int unsigned OP_W    = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB = 3'd1;
   localparam logic [OP_W-1:0] OP_MUL = 3'd2;
   localparam logic [OP_W-1:0] OP_SQR = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND_A  = 3'd1,
      ST_SEND_OP = 3'd2,
      ST_SEND_B  = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RESP    = 3'd5
   } state_e;

   // Opcodes above OP_SQR are never forwarded to calc.
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return (op <= OP_SQR);
   endfunction

endpackage

// File: rtl/calc_rr_arb.sv
// Request picker: round-robin from ptr+1, or lowest-index-wins when CALC_ARB_FIXED_PRI_EN is defined.
module calc_rr_arb
   import calc_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt_c,
   output logic [IDW-1:0]  idx_c,
   output logic            any_c
);

`ifdef CALC_ARB_FIXED_PRI_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Walk from the top so the lowest set index is written last and wins.
   always_comb begin
      logic [NREQ-1:0] sel;
      gnt_c = '0;
      idx_c = '0;
      any_c = |req;
      sel   = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         sel = req >> i;
         if (sel[0]) begin
            gnt_c = NREQ'(1) << i;
            idx_c = IDW'(i);
         end
      end
   end
`else
   // Walk the rotated order backwards so the first set bit after ptr is written last.
   always_comb begin
      logic [NREQ-1:0] sel;
      int unsigned     pos;
      gnt_c = '0;
      idx_c = '0;
      any_c = |req;
      sel   = '0;
      pos   = 0;
      for (int k = int'(NREQ); k >= 1; k--) begin
         pos = (32'(ptr) + 32'(k)) % NREQ;
         sel = req >> pos;
         if (sel[0]) begin
            gnt_c = NREQ'(1) << pos;
            idx_c = IDW'(pos);
         end
      end
   end
`endif

endmodule

// File: rtl/calc_arbiter.sv
// Shares one byte-serial calc among NREQ requesters and returns tagged results.
// Build option: CALC_ARB_FIXED_PRI_EN selects fixed priority instead of round-robin.
module calc_arbiter
   import calc_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = CALC_DW,
   parameter int unsigned IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_a,
   input  logic [NREQ*OP_W-1:0] req_op,
   input  logic [NREQ*DW-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [DW-1:0]        rsp_data,
   output logic                 rsp_err,
   output logic                 calc_rst,
   output logic                 calc_valid,
   output logic [DW-1:0]        calc_data,
   input  logic [DW-1:0]        calc_out
);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("calc_arbiter: NREQ must be 2..8");
   end
   if (DW != CALC_DW) begin : g_bad_dw
      $error("calc_arbiter: DW must match the calc datapath width");
   end
   if (IDW < $clog2(NREQ)) begin : g_bad_idw
      $error("calc_arbiter: IDW too narrow for NREQ");
   end

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DW-1:0]     b_q, b_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              calc_valid_q, calc_valid_d;
   logic [DW-1:0]     calc_data_q, calc_data_d;

   logic [NREQ-1:0]   gnt_c;
   logic [IDW-1:0]    gidx_c;
   logic              any_c;
   logic              accept_c;
   logic [IDW-1:0]    arb_ptr;
   logic [DW-1:0]     sel_a;
   logic [OP_W-1:0]   sel_op;
   logic [DW-1:0]     sel_b;

`ifdef CALC_ARB_FIXED_PRI_EN
   assign arb_ptr = '0;
`else
   logic [IDW-1:0]    ptr_q, ptr_d;
   assign arb_ptr = ptr_q;
`endif

   calc_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (req_valid),
      .ptr   (arb_ptr),
      .gnt_c (gnt_c),
      .idx_c (gidx_c),
      .any_c (any_c)
   );

   // Operands of the granted requester, taken straight from the packed buses.
   assign sel_a  = DW'(req_a >> (32'(gidx_c) * DW));
   assign sel_op = OP_W'(req_op >> (32'(gidx_c) * OP_W));
   assign sel_b  = DW'(req_b >> (32'(gidx_c) * DW));

   assign accept_c  = rst && (state_q == ST_IDLE) && any_c;
   assign req_ready = accept_c ? gnt_c : '0;

   // calc shares our reset edge so its 3-beat phase counter stays aligned with the FSM.
   assign calc_rst   = !rst;
   assign calc_valid = calc_valid_q;
   assign calc_data  = calc_data_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

   // Next state: the calc beat for a state is registered on entry, so it appears during that state.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      b_d          = b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      calc_valid_d = 1'b0;
      calc_data_d  = '0;
`ifndef CALC_ARB_FIXED_PRI_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               op_d     = sel_op;
               b_d      = sel_b;
               rsp_id_d = gidx_c;
`ifndef CALC_ARB_FIXED_PRI_EN
               ptr_d    = gidx_c;
`endif
               if (op_is_legal(sel_op)) begin
                  state_d      = ST_SEND_A;
                  calc_valid_d = 1'b1;
                  calc_data_d  = sel_a;
                  rsp_err_d    = 1'b0;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end
            end
         end
         ST_SEND_A: begin
            state_d      = ST_SEND_OP;
            calc_valid_d = 1'b1;
            calc_data_d  = DW'(op_q);
         end
         ST_SEND_OP: begin
            // Square ignores b but calc still expects a third beat.
            state_d      = ST_SEND_B;
            calc_valid_d = 1'b1;
            calc_data_d  = b_q;
         end
         ST_SEND_B: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d     = ST_RESP;
            rsp_data_d  = calc_out;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         b_q          <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         calc_valid_q <= 1'b0;
         calc_data_q  <= '0;
`ifndef CALC_ARB_FIXED_PRI_EN
         ptr_q        <= IDW'(NREQ - 1);
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         b_q          <= b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         calc_valid_q <= calc_valid_d;
         calc_data_q  <= calc_data_d;
`ifndef CALC_ARB_FIXED_PRI_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter with a behavioural calc, a transaction-level model and directed vectors.
module tb_calc_arbiter;
   import calc_pkg::*;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_a;
   logic [NREQ*3-1:0]    req_op;
   logic [NREQ*DW-1:0]   req_b;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [DW-1:0]        rsp_data;
   logic                 rsp_err;
   logic                 calc_rst;
   logic                 calc_valid;
   logic [DW-1:0]        calc_data;
   logic [DW-1:0]        calc_out;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int dut_gnt[$];

   calc_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_op     (req_op),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .calc_rst   (calc_rst),
      .calc_valid (calc_valid),
      .calc_data  (calc_data),
      .calc_out   (calc_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural calc: num1, op, num2 beats; result registered after the third beat.
   function automatic logic [7:0] calc_fn(input logic [7:0] x, input logic [2:0] o, input logic [7:0] y);
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_MUL:  return x * y;
         OP_SQR:  return x * x;
         default: return 8'h00;
      endcase
   endfunction

   logic [1:0] c_ph;
   logic [7:0] c_n1;
   logic [2:0] c_op;
   always @(posedge clk) begin
      if (calc_rst) begin
         c_ph     <= 2'd0;
         c_n1     <= 8'h00;
         c_op     <= 3'd0;
         calc_out <= 8'h00;
      end else if (calc_valid) begin
         case (c_ph)
            2'd0:    begin c_n1 <= calc_data; c_ph <= 2'd1; end
            2'd1:    begin c_op <= calc_data[2:0]; c_ph <= 2'd2; end
            default: begin calc_out <= calc_fn(c_n1, c_op, calc_data); c_ph <= 2'd0; end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Model helpers written from the arbitration and arithmetic rules directly.
   function automatic int model_grant(input logic [NREQ-1:0] rv, input int ptr);
      int base;
      base = ptr;
`ifdef CALC_ARB_FIXED_PRI_EN
      base = NREQ - 1;
`endif
      for (int k = 1; k <= NREQ; k++) begin
         if (rv[(base + k) % NREQ]) return (base + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int model_result(input int a, input int op, input int b);
      case (op)
         0:       return (a + b) % 256;
         1:       return (a - b + 256) % 256;
         2:       return (a * b) % 256;
         3:       return (a * a) % 256;
         default: return 0;
      endcase
   endfunction

   int m_busy = 0;
   int m_ptr  = NREQ - 1;
   int m_t    = 0;
   int m_rsp_t = 0;
   int m_id   = 0;
   int m_err  = 0;
   int m_a    = 0;
   int m_op   = 0;
   int m_b    = 0;
   int m_res  = 0;

   // Single compare process: every cycle, mid-period, outputs vs. the transaction model.
   always @(negedge clk) begin
      logic [NREQ-1:0] e_ready;
      logic            e_cv;
      int              e_cd;
      logic            e_rv;
      int              g;
      if (cyc >= 1) begin
         e_ready = '0;
         g       = -1;
         e_cv    = m_busy != 0 && m_err == 0 && cyc >= m_t + 1 && cyc <= m_t + 3;
         e_cd    = 0;
         if (e_cv) e_cd = (cyc == m_t + 1) ? m_a : (cyc == m_t + 2) ? m_op : m_b;
         e_rv    = m_busy != 0 && cyc >= m_rsp_t;
         if (m_busy == 0 && rst) begin
            g = model_grant(req_valid, m_ptr);
            if (g >= 0) e_ready[g] = 1'b1;
         end
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_gnt.push_back(i);

         chk("req_ready",  32'(req_ready),  32'(e_ready));
         chk("calc_rst",   32'(calc_rst),   32'(!rst));
         chk("calc_valid", 32'(calc_valid), 32'(e_cv));
         if (e_cv || m_busy == 0) chk("calc_data", 32'(calc_data), 32'(e_cd));
         chk("rsp_valid",  32'(rsp_valid),  32'(e_rv));
         if (e_rv) begin
            chk("rsp_id",   32'(rsp_id),   32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_res));
            chk("rsp_err",  32'(rsp_err),  32'(m_err));
         end

         if (!rst) begin
            m_busy = 0;
            m_ptr  = NREQ - 1;
         end else if (g >= 0) begin
            m_busy  = 1;
            m_ptr   = g;
            m_id    = g;
            m_t     = cyc;
            m_a     = int'(req_a[g*DW +: DW]);
            m_op    = int'(req_op[g*3 +: 3]);
            m_b     = int'(req_b[g*DW +: DW]);
            m_err   = (m_op > 3) ? 1 : 0;
            m_res   = model_result(m_a, m_op, m_b);
            m_rsp_t = (m_err != 0) ? cyc + 1 : cyc + 5;
         end else if (e_rv && rsp_ready) begin
            m_busy = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input int a, input int op, input int b);
      req_a[id*DW +: DW] = DW'(a);
      req_op[id*3 +: 3]  = 3'(op);
      req_b[id*DW +: DW] = DW'(b);
      req_valid[id]      = 1'b1;
   endtask

   // Raise one request, wait for its accept strobe, drop it; returns the accept cycle.
   task automatic issue(input int id, input int a, input int op, input int b, output int t_acc);
      set_req(id, a, op, b);
      #1;
      t_acc = -1;
      for (int i = 0; i < 40; i++) begin
         if (req_ready[id]) begin
            t_acc = cyc;
            break;
         end
         tick();
         #1;
      end
      if (t_acc < 0) chk("accept_timeout", 32'(0), 32'(1));
      else chk("ready_onehot", 32'(req_ready), 32'(1) << id);
      tick();
      req_valid[id] = 1'b0;
   endtask

   // Called one cycle after accept: checks the beats, latency and response literals.
   task automatic finish_req(input int t_acc, input int id, input int a, input int op, input int b,
                             input int exp_data, input int exp_err);
      int t_rsp;
      if (exp_err == 0) begin
         chk("beat_a_valid", 32'(calc_valid), 32'(1));
         chk("beat_a",       32'(calc_data),  32'(a));
         tick();
         chk("beat_op",      32'(calc_data),  32'(op));
         tick();
         chk("beat_b",       32'(calc_data),  32'(b));
         tick();
      end
      t_rsp = -1;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid) begin
            t_rsp = cyc;
            break;
         end
         if (exp_err != 0) chk("err_no_calc", 32'(calc_valid), 32'(0));
         tick();
      end
      chk("rsp_latency", 32'(t_rsp - t_acc), (exp_err != 0) ? 32'(1) : 32'(5));
      chk("rsp_id_lit",   32'(rsp_id),   32'(id));
      chk("rsp_data_lit", 32'(rsp_data), 32'(exp_data));
      chk("rsp_err_lit",  32'(rsp_err),  32'(exp_err));
      if (rsp_ready) tick();
   endtask

   task automatic run_req(input int id, input int a, input int op, input int b,
                          input int exp_data, input int exp_err);
      int t;
      issue(id, a, op, b, t);
      finish_req(t, id, a, op, b, exp_data, exp_err);
   endtask

   initial begin
      int t;
      int x;
      int exp_g[4];
      rst       = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_op    = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      repeat (3) tick();
      chk("rst_req_ready",  32'(req_ready),  32'(0));
      chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
      chk("rst_rsp_id",     32'(rsp_id),     32'(0));
      chk("rst_rsp_data",   32'(rsp_data),   32'(0));
      chk("rst_rsp_err",    32'(rsp_err),    32'(0));
      chk("rst_calc_valid", 32'(calc_valid), 32'(0));
      chk("rst_calc_data",  32'(calc_data),  32'(0));
      chk("rst_calc_rst",   32'(calc_rst),   32'(1));
      rst = 1'b1;
      #1;
      chk("rel_calc_rst",   32'(calc_rst),   32'(0));
      tick();

      run_req(0, 5,  OP_ADD, 3,  8'h08, 0);
      run_req(1, 3,  OP_SUB, 5,  8'hFE, 0);
      run_req(2, 20, OP_MUL, 20, 8'h90, 0);
      run_req(3, 12, OP_SQR, 99, 8'h90, 0);

      // Two requesters held continuously with immediate consumption.
      dut_gnt.delete();
      set_req(0, 10, OP_ADD, 20);
      set_req(2, 6,  OP_MUL, 7);
      for (int i = 0; i < 60 && dut_gnt.size() < 4; i++) tick();
      req_valid = '0;
      repeat (10) tick();
`ifdef CALC_ARB_FIXED_PRI_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 2, 0, 2};
`endif
      for (int k = 0; k < 4; k++)
         chk("grant_order", (k < dut_gnt.size()) ? 32'(dut_gnt[k]) : 32'hFFFF_FFFF, 32'(exp_g[k]));

      run_req(1, 4, 5, 6, 0, 1);
      run_req(0, 1, OP_ADD, 1, 2, 0);

      // Response back-pressure with another requester waiting.
      rsp_ready = 1'b0;
      issue(2, 7, OP_ADD, 9, t);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      set_req(0, 1, OP_ADD, 2);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
         chk("bp_rsp_id",    32'(rsp_id),    32'(2));
         chk("bp_rsp_data",  32'(rsp_data),  32'(16));
         chk("bp_rsp_err",   32'(rsp_err),   32'(0));
         chk("bp_req_ready", 32'(req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      x = cyc;
      issue(0, 1, OP_ADD, 2, t);
      chk("dead_cycle", 32'(t - x), 32'(1));
      finish_req(t, 0, 1, OP_ADD, 2, 3, 0);

      // Reset while the opcode beat is on the calc bus.
      issue(1, 9, OP_ADD, 9, t);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_calc_valid", 32'(calc_valid), 32'(0));
      for (int i = 0; i < 8; i++) begin
         chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
         tick();
      end
      run_req(1, 2, OP_ADD, 2, 4, 0);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got cyc=%0d, want completion", cyc);
      $fatal(1);
   end

endmodule
